hazard_stall_unit: RTL

- Producer-side complement to EX-stage operand forwarding.
- Detects RAW hazards that forwarding cannot resolve: load-use, and reads of a register still owned by the multi-cycle divider.
- Also detects structural conflicts on the divider.
- Drives the ID-stage stall and the ID/EX bubble, owns the divider occupancy counter, and keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_unit_if.sv | 34 +++
 rtl/hazard_stall_unit.sv | 82 ++++++++
 2 files changed

// File: rtl/hazard_stall_unit_if.sv
// ID/EX hazard-detection signal bundle: pipeline-side (master) drives ID/EX
// state, the hazard unit (slave) returns stall/bubble and divider status.
interface hazard_stall_unit_if #(
    parameter int PERF_W = 32
);
    logic              id_valid;
    logic [4:0]        id_rs1_addr;
    logic [4:0]        id_rs2_addr;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic              id_is_div;
    logic [4:0]        id_rd_addr;
    logic              ex_mem_read;
    logic [4:0]        ex_rd_addr;
    logic              ex_flush;
    logic              stall;
    logic              bubble_ex;
    logic              div_busy;
    logic              div_wb_valid;
    logic [4:0]        div_wb_rd;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_is_div, id_rd_addr, ex_mem_read, ex_rd_addr, ex_flush,
        input  stall, bubble_ex, div_busy, div_wb_valid, div_wb_rd, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_is_div, id_rd_addr, ex_mem_read, ex_rd_addr, ex_flush,
        output stall, bubble_ex, div_busy, div_wb_valid, div_wb_rd, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// ID-stage stall generation for hazards forwarding cannot cover (load-use,
// multi-cycle divider RAW/WAW/structural), plus divider tracking and a stall counter.
module hazard_stall_unit #(
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 4,
    parameter int PERF_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_stall_unit_if.slave   bus
);

    localparam logic [CNT_W-1:0] DIV_LAT_C = CNT_W'(DIV_LAT);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        div_rd_q, div_rd_d;
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

    logic div_busy;
    logic load_use;
    logic div_raw;
    logic div_struct;
    logic div_waw;
    logic stall;
    logic div_issue;

    function automatic logic src_hit(input logic used, input logic [4:0] addr,
                                     input logic [4:0] x);
        return used && (x != 5'd0) && (addr == x);
    endfunction

    always_comb begin
        div_busy   = (cnt_q != '0);
        load_use   = bus.ex_mem_read &&
                     (src_hit(bus.id_rs1_used, bus.id_rs1_addr, bus.ex_rd_addr) ||
                      src_hit(bus.id_rs2_used, bus.id_rs2_addr, bus.ex_rd_addr));
        div_raw    = div_busy &&
                     (src_hit(bus.id_rs1_used, bus.id_rs1_addr, div_rd_q) ||
                      src_hit(bus.id_rs2_used, bus.id_rs2_addr, div_rd_q));
        div_struct = div_busy && bus.id_is_div;
        // A younger write to the divider's rd must wait, or the late result would clobber it.
        div_waw    = div_busy && (bus.id_rd_addr != 5'd0) && (bus.id_rd_addr == div_rd_q);
        // A flushed ID instruction is dead, so none of its hazards matter.
        stall      = bus.id_valid && !bus.ex_flush &&
                     (load_use || div_raw || div_struct || div_waw);
        div_issue  = bus.id_valid && bus.id_is_div && !stall && !bus.ex_flush;

        cnt_d    = cnt_q;
        div_rd_d = div_rd_q;
        if (div_issue) begin
            cnt_d    = DIV_LAT_C;
            div_rd_d = bus.id_rd_addr;
        end else if (div_busy) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q          <= '0;
            div_rd_q       <= '0;
            stall_cycles_q <= '0;
        end else begin
            cnt_q          <= cnt_d;
            div_rd_q       <= div_rd_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.stall        = stall;
    assign bus.bubble_ex    = stall;
    assign bus.div_busy     = div_busy;
    assign bus.div_wb_valid = (cnt_q == CNT_W'(1));
    assign bus.div_wb_rd    = div_busy ? div_rd_q : 5'd0;
    assign bus.stall_cycles = stall_cycles_q;

endmodule
